// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises NUM_REQ cache clients onto one memory-controller port, round-robin by default.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
package mem_arbiter_pkg;
  typedef struct packed {
    logic         valid;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } mci_request_t;
  typedef struct packed {
    logic         ready;
    logic [127:0] data;
  } mci_response_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  mci_request_t  [NUM_REQ-1:0]    cli_req,
  output mci_response_t [NUM_REQ-1:0]    cli_res,
  output mci_request_t                   mem_req,
  input  mci_response_t                  mem_res,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant
);
  localparam int GW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] pend, slot_rw;
  logic [31:0]        slot_addr [NUM_REQ];
  logic [127:0]       slot_data [NUM_REQ];
  logic [GW-1:0]      winner;
  logic               req_rw;
  logic [31:0]        req_addr;
  logic [127:0]       req_data;
  logic               start, done;
  assign start = (state == IDLE) && (|pend);
  assign done  = (state == WAIT) && mem_res.ready;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = (state == IDLE)  ? (start ? ISSUE : IDLE) :
                (state == ISSUE) ? WAIT : (done ? IDLE : WAIT);
  end
`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (pend[i]) winner = GW'(i);
  end
`else
  logic [GW-1:0] ptr;
  // descending search distance, so the last hit is the nearest pending client at or above ptr
  always_comb begin
    winner = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      for (int i = 0; i < NUM_REQ; i++)
        if (pend[i] && i == (int'(ptr) + j) % NUM_REQ) winner = GW'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (done) ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + GW'(1);
  end
`endif
  // the completing owner's clear wins over any pulse it sends in the same cycle
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) pend[i] <= 1'b0;
      else if (done && grant == GW'(i)) pend[i] <= 1'b0;
      else if (cli_req[i].valid) pend[i] <= 1'b1;
      if (!rst && cli_req[i].valid && !pend[i]) begin
        slot_rw[i]   <= cli_req[i].rw;
        slot_addr[i] <= cli_req[i].addr;
        slot_data[i] <= cli_req[i].data;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      req_rw   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
    end else if (start) begin
      grant    <= winner;
      req_rw   <= slot_rw[winner];
      req_addr <= slot_addr[winner];
      req_data <= slot_data[winner];
    end
  end
  always_comb begin
    mem_req.valid = (state == ISSUE);
    mem_req.rw    = req_rw;
    mem_req.addr  = req_addr;
    mem_req.data  = req_data;
    busy          = (state != IDLE);
    for (int i = 0; i < NUM_REQ; i++) begin
      cli_res[i].ready = done && grant == GW'(i);
      cli_res[i].data  = mem_res.data;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level arbitration model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mci_request_t  [N-1:0] cli_req;
  mci_response_t [N-1:0] cli_res;
  mci_request_t          mem_req;
  mci_response_t         mem_res;
  logic                  busy;
  logic [$clog2(N)-1:0]  grant;
  int vecs = 0;
  int errs = 0;
  int mptr = 0;
  logic [127:0] mem_store [logic [31:0]];

  mem_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .cli_req(cli_req), .cli_res(cli_res),
    .mem_req(mem_req), .mem_res(mem_res), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic int pick(input bit [N-1:0] p, input int ptr);
`ifdef MEM_ARB_FIXED_PRIO_EN
    ptr = 0;
`endif
    for (int j = 0; j < N; j++) if (p[(ptr + j) % N]) return (ptr + j) % N;
    return -1;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) cli_req[i].valid = 1'b0;
    mem_res.ready = 1'b0;
  endtask

  task automatic pulse(input int c, input bit rw, input logic [31:0] a, input logic [127:0] d);
    cli_req[c].valid = 1'b1;
    cli_req[c].rw    = rw;
    cli_req[c].addr  = a;
    cli_req[c].data  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cli_req = '0;
    mem_res = '0;
    nxt();
    nxt();
    rst = 1'b0;
    mptr = 0;
  endtask

  // waits (bounded) for an issue, answers after dly cycles with data d, reports what was seen
  task automatic serve(input int dly, input logic [127:0] d, output bit issued, output int g,
                       output mci_request_t r, output logic [N-1:0] rdy, output logic [127:0] rdata,
                       output int lat);
    issued = 1'b0; g = -1; r = '0; rdy = '0; rdata = '0; lat = 0;
    for (int t = 0; t < 20 && !issued; t++) begin
      @(negedge clk);
      if (mem_req.valid) begin
        issued = 1'b1; g = int'(grant); r = mem_req;
      end else begin
        nxt(); lat++;
      end
    end
    if (!issued) return;
    repeat (dly) nxt();
    mem_res.ready = 1'b1;
    mem_res.data  = d;
    @(negedge clk);
    for (int i = 0; i < N; i++) rdy[i] = cli_res[i].ready;
    rdata = cli_res[g].data;
    nxt();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cli_req = '0;
    mem_res = '0;
    repeat (3) nxt();
    @(negedge clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (grant !== '0) begin errs++; $display("FAIL reset_grant got %0d want 0", grant); end
    vecs++; if (mem_req !== '0) begin errs++; $display("FAIL reset_mem_req got %h want 0", mem_req); end
    vecs++; if (cli_res[0].ready !== 1'b0 || cli_res[1].ready !== 1'b0) begin
      errs++; $display("FAIL reset_cli_ready got %b%b want 00", cli_res[1].ready, cli_res[0].ready); end
    nxt();
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic test_single_read();
    bit ok; int g, lat; mci_request_t r; logic [N-1:0] rdy; logic [127:0] rd;
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    pulse(0, 1'b0, 32'h0000_8000, '0);
    serve(3, d, ok, g, r, rdy, rd, lat);
    vecs++; if (!ok) begin errs++; $display("FAIL read_issue got none want one"); end
    vecs++; if (lat !== 2) begin errs++; $display("FAIL read_latency got %0d want 2", lat); end
    vecs++; if (r.addr !== 32'h8000 || r.rw !== 1'b0) begin
      errs++; $display("FAIL read_req got addr=%h rw=%b want 8000/0", r.addr, r.rw); end
    vecs++; if (g !== 0) begin errs++; $display("FAIL read_grant got %0d want 0", g); end
    vecs++; if (rdy !== 2'b01) begin errs++; $display("FAIL read_ready got %b want 01", rdy); end
    vecs++; if (rd !== d) begin errs++; $display("FAIL read_data got %h want %h", rd, d); end
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || cli_res[0].ready !== 1'b0) begin
      errs++; $display("FAIL read_after got busy=%b rdy=%b want 0/0", busy, cli_res[0].ready); end
    mptr = 1;
  endtask

  task automatic test_write_data();
    bit ok; int g, lat; mci_request_t r; logic [N-1:0] rdy; logic [127:0] rd;
    logic [127:0] w = {$urandom, $urandom, $urandom, 32'hba5e_ba11};
    do_reset();
    pulse(0, 1'b1, 32'h1230, w);
    serve(2, {$urandom, $urandom, $urandom, $urandom}, ok, g, r, rdy, rd, lat);
    vecs++; if (!ok || r.rw !== 1'b1 || r.addr !== 32'h1230 || r.data !== w) begin
      errs++; $display("FAIL write_req got ok=%b rw=%b addr=%h data=%h want 1/1/1230/%h", ok, r.rw, r.addr, r.data, w); end
    vecs++; if (rdy !== 2'b01) begin errs++; $display("FAIL write_ready got %b want 01", rdy); end
    if (ok) mem_store[r.addr] = r.data;
    pulse(0, 1'b0, 32'h1230, '0);
    serve(1, mem_store.exists(32'h1230) ? mem_store[32'h1230] : '0, ok, g, r, rdy, rd, lat);
    vecs++; if (!ok || r.rw !== 1'b0 || rd !== w) begin
      errs++; $display("FAIL readback got ok=%b rw=%b data=%h want 1/0/%h", ok, r.rw, rd, w); end
  endtask

  task automatic test_contention();
    bit ok; int g, lat, e, k; mci_request_t r; logic [N-1:0] rdy; logic [127:0] rd;
    bit [N-1:0] masks [4] = '{2'b11, 2'b11, 2'b01, 2'b11};
    bit [N-1:0] p;
    do_reset();
    foreach (masks[m]) begin
      p = masks[m];
      for (int i = 0; i < N; i++) if (p[i]) pulse(i, 1'b0, 32'h100 * (i + 1) + m, '0);
      k = 0;
      while (p != 0 && k < N) begin
        e = pick(p, mptr);
        serve(1 + (m % 2), '0, ok, g, r, rdy, rd, lat);
        vecs++; if (!ok || g !== e) begin
          errs++; $display("FAIL contention_order round %0d got %0d want %0d", m, g, e); end
        vecs++; if (rdy !== N'(1 << e)) begin
          errs++; $display("FAIL contention_ready round %0d got %b want %b", m, rdy, N'(1 << e)); end
        vecs++; if (lat !== (k == 0 ? 2 : 1)) begin
          errs++; $display("FAIL contention_gap round %0d got %0d want %0d", m, lat, k == 0 ? 2 : 1); end
        p[e] = 1'b0;
        mptr = (e + 1) % N;
        k++;
      end
    end
  endtask

  task automatic test_duplicate();
    bit ok; int g, lat, extra; mci_request_t r; logic [N-1:0] rdy; logic [127:0] rd;
    pulse(1, 1'b0, 32'h4444, '0);
    nxt();
    pulse(1, 1'b1, 32'h5555, '1);
    serve(2, '0, ok, g, r, rdy, rd, lat);
    vecs++; if (!ok || r.addr !== 32'h4444 || r.rw !== 1'b0) begin
      errs++; $display("FAIL dup_first got ok=%b addr=%h want 1/4444", ok, r.addr); end
    vecs++; if (rdy !== 2'b10) begin errs++; $display("FAIL dup_ready got %b want 10", rdy); end
    extra = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (mem_req.valid) extra++;
      nxt();
    end
    vecs++; if (extra !== 0) begin errs++; $display("FAIL dup_extra got %0d want 0", extra); end
    mptr = 0;
  endtask

  task automatic test_stray_ready();
    mem_res.ready = 1'b1;
    mem_res.data  = '1;
    @(negedge clk);
    vecs++; if (cli_res[0].ready !== 1'b0 || cli_res[1].ready !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL stray_ready got rdy=%b%b busy=%b want 00/0", cli_res[1].ready, cli_res[0].ready, busy); end
    nxt();
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || mem_req.valid !== 1'b0) begin
      errs++; $display("FAIL stray_state got busy=%b valid=%b want 0/0", busy, mem_req.valid); end
  endtask

  task automatic test_reset_wait();
    bit ok; int g, lat, extra; mci_request_t r; logic [N-1:0] rdy; logic [127:0] rd;
    pulse(1, 1'b0, 32'h7770, '0);
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      ok = mem_req.valid;
      nxt();
    end
    vecs++; if (!ok) begin errs++; $display("FAIL rstwait_issue got none want one"); end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    mem_res.ready = 1'b1;
    @(negedge clk);
    vecs++; if (cli_res[0].ready !== 1'b0 || cli_res[1].ready !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL rstwait_ready got rdy=%b%b busy=%b want 00/0", cli_res[1].ready, cli_res[0].ready, busy); end
    mptr = 0;
    extra = 0;
    for (int t = 0; t < 4; t++) begin
      nxt();
      @(negedge clk);
      if (mem_req.valid || busy) extra++;
    end
    vecs++; if (extra !== 0) begin errs++; $display("FAIL rstwait_pend got %0d busy cycles want 0", extra); end
    nxt();
    pulse(1, 1'b1, 32'h7780, 128'h1234);
    serve(1, '0, ok, g, r, rdy, rd, lat);
    vecs++; if (!ok || g !== 1 || r.addr !== 32'h7780 || rdy !== 2'b10) begin
      errs++; $display("FAIL rstwait_next got ok=%b g=%0d addr=%h rdy=%b want 1/1/7780/10", ok, g, r.addr, rdy); end
    mptr = 0;
  endtask

  task automatic test_random();
    bit [N-1:0] mp, pprev;
    logic [31:0] ma [N];
    bit mrw [N];
    logic [127:0] md [N];
    logic [127:0] rdat;
    bit infl, iss, rdy_now, was_infl, last_valid;
    int own, cnt;
    do_reset();
    mp = '0; infl = 0; iss = 0; own = 0; cnt = 0; last_valid = 0; rdat = '0;
    for (int c = 0; c < 600; c++) begin
      nxt();
      rdy_now = infl && !iss && cnt == 0;
      if (rdy_now) begin
        rdat = mrw[own] ? {$urandom, $urandom, $urandom, $urandom}
                        : (mem_store.exists(ma[own]) ? mem_store[ma[own]] : '0);
        mem_res.ready = 1'b1;
        mem_res.data  = rdat;
      end else if (!infl && $urandom_range(0, 7) == 0) begin
        mem_res.ready = 1'b1;
        mem_res.data  = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0 && !(rdy_now && own == i))
          pulse(i, 1'($urandom), 32'h40 * $urandom_range(0, 7), {$urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
      vecs++; if (mem_req.valid !== iss) begin
        errs++; $display("FAIL rand_valid cyc %0d got %b want %b", c, mem_req.valid, iss); end
      vecs++; if (mem_req.valid && last_valid) begin
        errs++; $display("FAIL rand_double_valid cyc %0d got 11 want 0 after 1", c); end
      last_valid = mem_req.valid;
      if (iss) begin
        vecs++; if (int'(grant) !== own || mem_req.addr !== ma[own] || mem_req.rw !== mrw[own] || mem_req.data !== md[own]) begin
          errs++; $display("FAIL rand_req cyc %0d got g=%0d addr=%h rw=%b want g=%0d addr=%h rw=%b",
                           c, grant, mem_req.addr, mem_req.rw, own, ma[own], mrw[own]); end
      end
      for (int i = 0; i < N; i++) begin
        vecs++; if (cli_res[i].ready !== (rdy_now && own == i)) begin
          errs++; $display("FAIL rand_ready cyc %0d port %0d got %b want %b", c, i, cli_res[i].ready, rdy_now && own == i); end
      end
      if (rdy_now) begin
        vecs++; if (cli_res[own].data !== rdat) begin
          errs++; $display("FAIL rand_data cyc %0d got %h want %h", c, cli_res[own].data, rdat); end
      end
      vecs++; if (busy !== infl) begin errs++; $display("FAIL rand_busy cyc %0d got %b want %b", c, busy, infl); end
      pprev = mp;
      was_infl = infl;
      if (rdy_now) begin
        if (mrw[own]) mem_store[ma[own]] = md[own];
        mp[own] = 1'b0;
        mptr = (own + 1) % N;
        infl = 1'b0;
      end else if (iss) begin
        iss = 1'b0;
        cnt = $urandom_range(0, 3);
      end else if (infl) cnt--;
      for (int i = 0; i < N; i++)
        if (cli_req[i].valid && !pprev[i]) begin
          mp[i] = 1'b1; ma[i] = cli_req[i].addr; mrw[i] = cli_req[i].rw; md[i] = cli_req[i].data;
        end
      if (!was_infl && pprev != 0) begin
        own = pick(pprev, mptr);
        iss = 1'b1;
        infl = 1'b1;
      end
    end
  endtask

  initial begin
    cli_req = '0;
    mem_res = '0;
    test_reset();
    test_single_read();
    test_write_data();
    test_contention();
    test_duplicate();
    test_stray_ready();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
